// File: rtl/gray_pkg.sv
// Shared types and constants for the gray-mean binarization stage.
// Gray is carried in the red byte of an RGB888 word.
package gray_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StP1Rd,
    StP1Wait,
    StDiv,
    StP2Rd,
    StP2Wait,
    StDone
  } state_e;

  localparam logic [23:0] PIX_WHITE = 24'hFFFFFF;
  localparam logic [23:0] PIX_BLACK = 24'h000000;

  localparam int unsigned GRAY_MSB = 23;
  localparam int unsigned GRAY_LSB = 16;

  function automatic logic [7:0] gray_of(input logic [23:0] px);
    return px[GRAY_MSB:GRAY_LSB];
  endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring divider, one quotient bit per cycle. The first bit is resolved in the start cycle,
// so valid pulses exactly N_W cycles after start. A zero divisor yields an all-ones quotient.
module seq_div #(
  parameter int unsigned N_W = 16,
  parameter int unsigned D_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           valid,
  output logic [N_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(N_W + 1);

  logic [N_W-1:0]   quo_q, quo_d;
  logic [D_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic             start_ok;
  logic [N_W-1:0]   quo_in;
  logic [D_W-1:0]   rem_in;
  logic [D_W:0]     trial;
  logic             fits;

  assign start_ok = start && !busy_q;

  always_comb begin
    quo_in  = start_ok ? dividend : quo_q;
    rem_in  = start_ok ? '0 : rem_q;
    trial   = {rem_in, quo_in[N_W-1]};
    fits    = (trial >= {1'b0, divisor});
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    if (start_ok || busy_q) begin
      quo_d = {quo_in[N_W-2:0], fits};
      rem_d = fits ? D_W'(trial - {1'b0, divisor}) : trial[D_W-1:0];
      if (start_ok) begin
        cnt_d  = CNT_W'(N_W - 1);
        busy_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign quotient = quo_q;

endmodule

// File: rtl/gray_mean_binarize.sv
// Two-pass global-mean binarizer: pass 1 sums the gray frame, a sequential divide yields the
// mean, pass 2 rereads each pixel and writes white (>= mean) or black.
module gray_mean_binarize
  import gray_pkg::*;
#(
  parameter int unsigned V_SIZE = 4,
  parameter int unsigned H_SIZE = 4,
  localparam int unsigned IMG_SIZE = V_SIZE * H_SIZE,
  localparam int unsigned ADDR_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1,
  localparam int unsigned ACC_W = 8 + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_pixel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              pixel_val,
  input  logic [23:0]       pixel_in,
  output logic              wr_pixel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       pixel_out,
  output logic              busy,
  output logic [7:0]        mean,
  output logic              done
);

  localparam int unsigned       DIV_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);
  localparam logic [DIV_W-1:0]  DIVISOR   = DIV_W'(IMG_SIZE);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_pixel_q, wr_pixel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       pixel_out_q, pixel_out_d;
  logic              busy_q, busy_d;
  logic [7:0]        mean_q, mean_d;
  logic              done_q, done_d;

  logic              div_start;
  logic              div_busy;
  logic              div_valid;
  logic [ACC_W-1:0]  div_quo;
  logic [7:0]        gray;
  logic              last_addr;

  assign gray      = gray_of(pixel_in);
  assign last_addr = (rd_addr_q == LAST_ADDR);

  seq_div #(
    .N_W(ACC_W),
    .D_W(DIV_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(acc_q),
    .divisor (DIVISOR),
    .busy    (div_busy),
    .valid   (div_valid),
    .quotient(div_quo)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rd_addr_d   = rd_addr_q;
    wr_pixel_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    pixel_out_d = pixel_out_q;
    busy_d      = busy_q;
    mean_d      = mean_q;
    done_d      = done_q;
    div_start   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          acc_d     = '0;
          rd_addr_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = StP1Rd;
        end
      end
      StP1Rd: state_d = StP1Wait;
      StP1Wait: begin
        if (pixel_val) begin
          acc_d = acc_q + ACC_W'(gray);
          if (last_addr) begin
            rd_addr_d = '0;
            state_d   = StDiv;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = StP1Rd;
          end
        end
      end
      StDiv: begin
        // Kick the divider once; it is idle only on the first DIV cycle.
        div_start = !div_busy && !div_valid;
        if (div_valid) begin
          mean_d  = (|div_quo[ACC_W-1:8]) ? 8'hFF : div_quo[7:0];
          state_d = StP2Rd;
        end
      end
      StP2Rd: state_d = StP2Wait;
      StP2Wait: begin
        if (pixel_val) begin
          wr_pixel_d  = 1'b1;
          wr_addr_d   = rd_addr_q;
          pixel_out_d = (gray >= mean_q) ? PIX_WHITE : PIX_BLACK;
          if (last_addr) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = StP2Rd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      rd_addr_q   <= '0;
      wr_pixel_q  <= 1'b0;
      wr_addr_q   <= '0;
      pixel_out_q <= '0;
      busy_q      <= 1'b0;
      mean_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rd_addr_q   <= rd_addr_d;
      wr_pixel_q  <= wr_pixel_d;
      wr_addr_q   <= wr_addr_d;
      pixel_out_q <= pixel_out_d;
      busy_q      <= busy_d;
      mean_q      <= mean_d;
      done_q      <= done_d;
    end
  end

  assign rd_pixel  = (state_q == StP1Rd) || (state_q == StP2Rd);
  assign rd_addr   = rd_addr_q;
  assign wr_pixel  = wr_pixel_q;
  assign wr_addr   = wr_addr_q;
  assign pixel_out = pixel_out_q;
  assign busy      = busy_q;
  assign mean      = mean_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_mean_binarize.sv
// Bench for gray_mean_binarize: three frame geometries (2x2, 3x1, 1x1) behind a select mux,
// a delayed-response memory model, and a vector table of hand-computed means and outputs.
module tb_gray_mean_binarize;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start_s, pv_s;
  logic [23:0] pin_s;
  int sel;

  always #5 clk = ~clk;

  logic        start0, start1, start2;
  logic        rd0, rd1, rd2, wr0, wr1, wr2, busy0, busy1, busy2, done0, done1, done2;
  logic [1:0]  ra0, ra1, wa0, wa1;
  logic [0:0]  ra2, wa2;
  logic [23:0] po0, po1, po2;
  logic [7:0]  mean0, mean1, mean2;

  assign start0 = start_s && (sel == 0);
  assign start1 = start_s && (sel == 1);
  assign start2 = start_s && (sel == 2);

  gray_mean_binarize #(.V_SIZE(2), .H_SIZE(2)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .rd_pixel(rd0), .rd_addr(ra0),
    .pixel_val(pv_s && (sel == 0)), .pixel_in(pin_s), .wr_pixel(wr0), .wr_addr(wa0),
    .pixel_out(po0), .busy(busy0), .mean(mean0), .done(done0));
  gray_mean_binarize #(.V_SIZE(3), .H_SIZE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rd_pixel(rd1), .rd_addr(ra1),
    .pixel_val(pv_s && (sel == 1)), .pixel_in(pin_s), .wr_pixel(wr1), .wr_addr(wa1),
    .pixel_out(po1), .busy(busy1), .mean(mean1), .done(done1));
  gray_mean_binarize #(.V_SIZE(1), .H_SIZE(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .rd_pixel(rd2), .rd_addr(ra2),
    .pixel_val(pv_s && (sel == 2)), .pixel_in(pin_s), .wr_pixel(wr2), .wr_addr(wa2),
    .pixel_out(po2), .busy(busy2), .mean(mean2), .done(done2));

  logic        rd_m, wr_m, busy_m, done_m, dstart_m, dvalid_m;
  logic [1:0]  ra_m, wa_m;
  logic [23:0] po_m;
  logic [7:0]  mean_m;
  state_e      state_m;

  always_comb begin
    rd_m = rd0; ra_m = ra0; wr_m = wr0; wa_m = wa0; po_m = po0; busy_m = busy0;
    mean_m = mean0; done_m = done0; state_m = u_dut0.state_q;
    dstart_m = u_dut0.div_start; dvalid_m = u_dut0.div_valid;
    if (sel == 1) begin
      rd_m = rd1; ra_m = ra1; wr_m = wr1; wa_m = wa1; po_m = po1; busy_m = busy1;
      mean_m = mean1; done_m = done1; state_m = u_dut1.state_q;
      dstart_m = u_dut1.div_start; dvalid_m = u_dut1.div_valid;
    end else if (sel == 2) begin
      rd_m = rd2; ra_m = {1'b0, ra2}; wr_m = wr2; wa_m = {1'b0, wa2}; po_m = po2;
      busy_m = busy2; mean_m = mean2; done_m = done2; state_m = u_dut2.state_q;
      dstart_m = u_dut2.div_start; dvalid_m = u_dut2.div_valid;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int         sel;
    int         dly;
    bit         spur;
    logic [7:0] pix [4];
    logic [7:0] mean;
    bit         white [4];
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];
  int   img_of   [3] = '{4, 3, 1};
  int   accw_of  [3] = '{10, 10, 9};

  logic [7:0]  mem [4];
  logic [23:0] wdata [4];
  int nwr, nrd, t_start, t_valid;
  bit order_ok, finished;

  function automatic logic [23:0] pix_word(input logic [7:0] g);
    return {g, ~g, g ^ 8'h3C};
  endfunction

  // Drives one frame: start pulse, memory responses after dly cycles, optional spurious
  // pixel_val while no request is outstanding, optional extra start, optional reset abort.
  task automatic run_frame(input int dly, input bit spur, input int abort_wr,
                           input int extra_start);
    int cnt;
    bit pend;
    logic [1:0] paddr;
    nwr = 0; nrd = 0; order_ok = 1'b1; finished = 1'b0; t_start = -1; t_valid = -1;
    pend = 1'b0; cnt = 0; paddr = '0;
    for (int i = 0; i < 4; i++) wdata[i] = 24'h5A5A5A;
    @(negedge clk);
    start_s = 1'b1; pv_s = 1'b0; pin_s = '0;
    @(negedge clk);
    start_s = 1'b0;
    chk("busy_after_start", 32'(busy_m), 32'd1);
    chk("done_after_start", 32'(done_m), 32'd0);
    for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
      start_s = (cyc == extra_start);
      if (wr_m) begin
        if (int'(wa_m) != nwr) order_ok = 1'b0;
        wdata[wa_m] = po_m;
        nwr++;
      end
      if (dstart_m && t_start < 0) t_start = cyc;
      if (dvalid_m && t_valid < 0) t_valid = cyc;
      if (done_m) begin
        finished = 1'b1; pv_s = 1'b0; start_s = 1'b0;
      end else if (abort_wr >= 0 && nwr == abort_wr && pend) begin
        finished = 1'b1; pv_s = 1'b0; start_s = 1'b0; reset = 1'b1;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pv_s = 1'b1; pin_s = pix_word(mem[paddr]); pend = 1'b0;
        end else begin
          pv_s = 1'b0; pin_s = '0;
        end
      end else if (rd_m) begin
        nrd++; pend = 1'b1; cnt = dly; paddr = ra_m; pv_s = spur; pin_s = '0;
      end else begin
        pv_s = spur; pin_s = '0;
      end
      if (!finished) @(negedge clk);
    end
  endtask

  task automatic check_frame(input int s, input logic [7:0] emean, input bit white [4]);
    chk("frame_finished", 32'(finished), 32'd1);
    chk("mean", 32'(mean_m), 32'(emean));
    chk("write_count", nwr, img_of[s]);
    chk("write_order", 32'(order_ok), 32'd1);
    chk("read_count", nrd, 2 * img_of[s]);
    chk("div_latency", t_valid - t_start, accw_of[s]);
    chk("done_end", 32'(done_m), 32'd1);
    chk("busy_end", 32'(busy_m), 32'd0);
    for (int i = 0; i < img_of[s]; i++)
      chk($sformatf("pixel_out[%0d]", i), 32'(wdata[i]), 32'(white[i] ? PIX_WHITE : PIX_BLACK));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_pixel"}, 32'(rd_m), 0);
    chk({tag, "_rd_addr"}, 32'(ra_m), 0);
    chk({tag, "_wr_pixel"}, 32'(wr_m), 0);
    chk({tag, "_wr_addr"}, 32'(wa_m), 0);
    chk({tag, "_pixel_out"}, 32'(po_m), 0);
    chk({tag, "_busy"}, 32'(busy_m), 0);
    chk({tag, "_mean"}, 32'(mean_m), 0);
    chk({tag, "_done"}, 32'(done_m), 0);
    chk({tag, "_state"}, 32'(state_m), 32'(StIdle));
  endtask

  initial begin
    // sel, dly, spur, pixels, mean, white mask (pixel i white when gray_i >= mean)
    vecs[0] = '{0, 1, 1'b0, '{8'd10, 8'd20, 8'd30, 8'd40}, 8'd25, '{0, 0, 1, 1}};
    vecs[1] = '{1, 1, 1'b0, '{8'd0, 8'd0, 8'd1, 8'd0}, 8'd0, '{1, 1, 1, 0}};
    vecs[2] = '{0, 3, 1'b1, '{8'd255, 8'd255, 8'd255, 8'd255}, 8'd255, '{1, 1, 1, 1}};
    vecs[3] = '{2, 1, 1'b0, '{8'd0, 8'd0, 8'd0, 8'd0}, 8'd0, '{1, 0, 0, 0}};
    vecs[4] = '{0, 2, 1'b0, '{8'd200, 8'd100, 8'd50, 8'd51}, 8'd100, '{1, 1, 0, 0}};
    vecs[5] = '{1, 2, 1'b1, '{8'd7, 8'd8, 8'd9, 8'd0}, 8'd8, '{0, 1, 1, 0}};

    sel = 0; reset = 1'b1; start_s = 1'b0; pv_s = 1'b0; pin_s = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_reset_state($sformatf("reset%0d", s));
    end
    reset = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      sel = vecs[v].sel;
      for (int i = 0; i < 4; i++) mem[i] = vecs[v].pix[i];
      run_frame(vecs[v].dly, vecs[v].spur, -1, -1);
      check_frame(vecs[v].sel, vecs[v].mean, vecs[v].white);
    end

    // Reset while awaiting the third pass-2 read, then a clean rerun.
    sel = 0;
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    run_frame(3, 1'b0, 2, -1);
    chk("abort_write_count", nwr, 2);
    @(negedge clk);
    chk_reset_state("midreset");
    reset = 1'b0;
    run_frame(1, 1'b0, -1, -1);
    check_frame(0, 8'd25, '{0, 0, 1, 1});

    // Start during pass 1 is ignored; a second start from DONE reprocesses identically.
    run_frame(1, 1'b0, -1, 3);
    check_frame(0, 8'd25, '{0, 0, 1, 1});
    run_frame(2, 1'b0, -1, -1);
    check_frame(0, 8'd25, '{0, 0, 1, 1});

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1; start_s = 1'b1;
    @(negedge clk);
    reset = 1'b0; start_s = 1'b0;
    chk("rst_start_busy", 32'(busy_m), 0);
    chk("rst_start_done", 32'(done_m), 0);
    chk("rst_start_state", 32'(state_m), 32'(StIdle));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_mean_binarize.md
Name: gray_mean_binarize

Overview:
Downstream stage of the gray-conversion block. Reads a gray RGB888 frame from frame memory, where R=G=B and only [23:16] is used. Pass 1 sums every pixel and computes the global mean. Pass 2 rereads each pixel and writes 24'hFFFFFF if gray >= mean, else 24'h000000. It uses the same request/valid memory handshake as the gray stage, with a separate write address.

Parameters:
V_SIZE, 4, image rows (>=1)
H_SIZE, 4, image columns (>=1)
IMG_SIZE, V_SIZE*H_SIZE, derived localparam, pixel count
ADDR_W, $clog2(IMG_SIZE) (min 1), derived localparam, address width
ACC_W, 8+ADDR_W, derived localparam, accumulator width; no overflow possible

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins processing; honoured only in IDLE or DONE
rd_pixel  out  1  one-cycle read request for rd_addr
rd_addr  out  ADDR_W  read address, row-major, 0..IMG_SIZE-1
pixel_val  in  1  read data valid; only meaningful while awaiting a request
pixel_in  in  24  read data; [23:16] taken as gray
wr_pixel  out  1  one-cycle write strobe
wr_addr  out  ADDR_W  write address, valid with wr_pixel
pixel_out  out  24  binary pixel, valid with wr_pixel
busy  out  1  high from start acceptance until DONE entry
mean  out  8  computed mean; valid from DIV exit until next start
done  out  1  sticky completion flag; cleared by accepted start or reset

Behaviour:
- Reset (synchronous, any state, including mid-pass): state=IDLE. All outputs 0: rd_pixel, rd_addr, wr_pixel, wr_addr, pixel_out, busy, mean, done. Accumulator and divider cleared.
- States: IDLE, P1_RD, P1_WAIT, DIV, P2_RD, P2_WAIT, DONE.
- IDLE/DONE + start: acc<=0, rd_addr<=0, done<=0, busy<=1, go P1_RD.
- P1_RD: rd_pixel=1 for exactly one cycle, go P1_WAIT.
- P1_WAIT: rd_pixel=0. Wait any number of cycles for pixel_val.
  - On pixel_val: acc<=acc+pixel_in[23:16].
  - If rd_addr==IMG_SIZE-1: rd_addr<=0, go DIV. Else rd_addr+1, go P1_RD.
- DIV: start the sequential divider, acc / IMG_SIZE, floor.
  - Fixed latency ACC_W cycles from start to result valid.
  - On result valid: mean<=quotient[7:0]. The quotient is always <=255 by construction. Go P2_RD.
- P2_RD: rd_pixel pulse, go P2_WAIT.
- P2_WAIT: on pixel_val, in the same edge:
  - wr_pixel<=1, wr_addr<=rd_addr.
  - pixel_out <= (pixel_in[23:16] >= mean) ? 24'hFFFFFF : 24'h000000.
  - Last address: go DONE. Else rd_addr+1, go P2_RD.
- wr_pixel is high exactly one cycle per pixel; IMG_SIZE write strobes total.
- DONE: busy=0, done=1 (sticky), rd_pixel=0, wr_pixel=0.
- Minimum per-pixel cost is 2 cycles (request + valid next cycle).
  - Total minimum = 4*IMG_SIZE + ACC_W + small constant.
- pixel_val outside P1_WAIT/P2_WAIT: ignored, no state or data change.
- start while busy: ignored.
- start and reset in the same cycle: reset wins.
- IMG_SIZE==1: single pixel. mean equals that pixel, so the output is FFFFFF.

Decomposition:
- Package gray_pkg holds:
  - state enum
  - PIX_WHITE=24'hFFFFFF and PIX_BLACK=24'h000000
  - GRAY_MSB=23, GRAY_LSB=16
- Sub-module seq_div, a restoring divider:
  - parameters: N_W (dividend width), D_W (divisor width)
  - ports: clk, reset, start, dividend, divisor, busy, valid (1-cycle pulse), quotient
  - fixed N_W-cycle latency
  - divisor 0 never occurs here; it returns all-ones

Test Plan:
- 2x2 image, pixels 10,20,30,40, pixel_val 1 cycle after each rd_pixel -> mean=25; writes addr0..3 = 000000,000000,FFFFFF,FFFFFF; done=1, busy=0.
- 3x1 image (non-power-of-two), pixels 0,0,1 -> sum=1, mean=0; all three outputs FFFFFF.
- 2x2 all 255, pixel_val delayed 3 cycles and spurious pixel_val pulses in P1_RD/DIV -> sum=1020, mean=255, all outputs FFFFFF, exactly 4 wr_pixel strobes.
- Reset asserted during P2_WAIT after 2 writes -> next cycle all outputs 0, state IDLE. New start reprocesses from addr 0 with correct mean.
- start pulsed mid pass 1 -> ignored, no restart. Completion followed by a second start -> done clears the next cycle and the frame reprocesses identically.
- 1x1 image, pixel 0 -> mean=0, single write FFFFFF at addr 0; divider latency = ACC_W cycles measured.
